// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with fetch handshake.
// Chooses the next PC from trap vector, aligned redirect target or sequential
// increment (+4, or +2 for compressed instructions when C_EXT=1). Presents pc
// to fetch via fetch_valid/fetch_ready, supports stall and halt, rejects
// misaligned redirect targets and counts accepted sequential fetches.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   stall                            hold PC (back-pressure)
//   halt_req                         stop issuing fetches while high
//   redirect_valid/redirect_target   taken branch/jump
//   trap_valid/trap_vector           trap redirect (highest priority)
//   instr_c                          instruction at pc is compressed
//   fetch_ready                      fetch stage accepts pc
//   fetch_valid                      pc is a valid fetch address (registered)
//   pc                               current PC (registered)
//   pc_next                          value pc takes on the next edge (comb)
//   misaligned_err                   one-cycle pulse on a rejected redirect
//   misaligned_addr                  last rejected redirect target
//   fetch_count                      accepted sequential fetches (wraps)
module pc_unit #(
  parameter int unsigned XLEN              = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
  parameter bit          C_EXT             = 1'b0,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             instr_c,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_next,
  output logic             misaligned_err,
  output logic [XLEN-1:0]  misaligned_addr,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               boot_seen_q, boot_seen_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               handshake;
  logic               target_misaligned;
  logic [XLEN-1:0]    pc_step;

  // Bit 0 always illegal; bit 1 illegal only without compressed support.
  assign target_misaligned = redirect_target[0] | (~C_EXT & redirect_target[1]);
  assign handshake         = fetch_valid_q & fetch_ready;
  assign pc_step           = (C_EXT && instr_c) ? XLEN'(2) : XLEN'(4);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      boot_seen_q   <= 1'b0;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      boot_seen_q   <= boot_seen_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state, next-PC and bookkeeping.
  always_comb begin
    state_d     = state_q;
    boot_seen_d = boot_seen_q;
    pc_d        = pc_q;
    err_d       = 1'b0;
    addr_d      = addr_q;
    cnt_d       = cnt_q;

    // The first edge after reset release only arms BOOT; the second leaves
    // it, so fetch_valid first rises on the second edge.
    unique case (state_q)
      S_BOOT: begin
        boot_seen_d = 1'b1;
        if (boot_seen_q) state_d = S_RUN;
      end
      S_RUN:    state_d = halt_req ? S_HALTED : S_RUN;
      S_HALTED: state_d = halt_req ? S_HALTED : S_RUN;
      default:  state_d = S_BOOT;
    endcase

    if (state_q != S_BOOT) begin
      if (trap_valid) begin
        pc_d = trap_vector;
      end else if (redirect_valid && !target_misaligned) begin
        pc_d = redirect_target;
      end else if (handshake && !stall && (state_q == S_RUN)) begin
        pc_d  = pc_q + pc_step;
        cnt_d = cnt_q + CNT_W'(1);
      end

      // A concurrent trap suppresses the alignment check entirely.
      if (redirect_valid && !trap_valid && target_misaligned) begin
        err_d  = 1'b1;
        addr_d = redirect_target;
      end
    end

    fetch_valid_d = (state_d == S_RUN);
  end

  assign pc              = pc_q;
  assign pc_next         = pc_d;
  assign fetch_valid     = fetch_valid_q;
  assign misaligned_err  = err_q;
  assign misaligned_addr = addr_q;
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, halt_req, redirect_valid, trap_valid, instr_c, fetch_ready;
  logic [31:0] redirect_target, trap_vector;

  logic        fv0, fv1, err0, err1;
  logic [31:0] pc0, pc1, pcn0, pcn1, addr0, addr1, cnt0;
  logic [3:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: word-aligned only, 32-bit counter.
  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .instr_c(instr_c),
    .fetch_ready(fetch_ready), .fetch_valid(fv0), .pc(pc0), .pc_next(pcn0),
    .misaligned_err(err0), .misaligned_addr(addr0), .fetch_count(cnt0));

  // Instance 1: compressed enabled, 4-bit counter so wrap is exercised.
  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .instr_c(instr_c),
    .fetch_ready(fetch_ready), .fetch_valid(fv1), .pc(pc1), .pc_next(pcn1),
    .misaligned_err(err1), .misaligned_addr(addr1), .fetch_count(cnt1));

  logic        o_fv  [2];
  logic        o_err [2];
  logic [31:0] o_pc  [2];
  logic [31:0] o_pcn [2];
  logic [31:0] o_addr[2];
  logic [31:0] o_cnt [2];
  assign o_fv[0] = fv0;     assign o_fv[1] = fv1;
  assign o_err[0] = err0;   assign o_err[1] = err1;
  assign o_pc[0] = pc0;     assign o_pc[1] = pc1;
  assign o_pcn[0] = pcn0;   assign o_pcn[1] = pcn1;
  assign o_addr[0] = addr0; assign o_addr[1] = addr1;
  assign o_cnt[0] = cnt0;   assign o_cnt[1] = {28'h0, cnt1};

  // Behavioural model: index 0 = no compressed, index 1 = compressed.
  logic [31:0] mpc  [2];
  int          mboot[2];
  bit          mhalt[2];
  logic [31:0] mcnt [2];
  bit          merr [2];
  logic [31:0] maddr[2];

  function automatic bit m_mis(logic [31:0] t, bit c);
    return t[0] | (!c && t[1]);
  endfunction

  function automatic bit m_seq(int i);
    return mboot[i] == 0 && !mhalt[i] && fetch_ready && !stall && !trap_valid &&
           !(redirect_valid && !m_mis(redirect_target, i == 1));
  endfunction

  function automatic logic [31:0] m_next(int i);
    if (mboot[i] != 0) return mpc[i];
    if (trap_valid) return trap_vector;
    if (redirect_valid && !m_mis(redirect_target, i == 1)) return redirect_target;
    if (m_seq(i)) return mpc[i] + ((i == 1 && instr_c) ? 32'd2 : 32'd4);
    return mpc[i];
  endfunction

  function automatic bit m_fv(int i);
    return mboot[i] == 0 && !mhalt[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mpc[i] = 32'h0000_1000; mboot[i] = 2; mhalt[i] = 1'b0;
      mcnt[i] = 32'h0; merr[i] = 1'b0; maddr[i] = 32'h0;
    end
  endtask

  // One clock: capture model transition, take the edge, settle.
  task automatic tick();
    logic [31:0] np[2];
    bit          sq[2];
    bit          e[2];
    logic [31:0] tgt;
    tgt = redirect_target;
    for (int i = 0; i < 2; i++) begin
      np[i] = m_next(i);
      sq[i] = m_seq(i);
      e[i]  = mboot[i] == 0 && redirect_valid && !trap_valid && m_mis(tgt, i == 1);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mpc[i] = np[i];
      if (sq[i]) mcnt[i] = (i == 1) ? ((mcnt[i] + 32'd1) & 32'hF) : mcnt[i] + 32'd1;
      merr[i] = e[i];
      if (e[i]) maddr[i] = tgt;
      if (mboot[i] != 0) mboot[i]--;
      else mhalt[i] = halt_req;
    end
    #1;
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; redirect_valid = 0; trap_valid = 0; instr_c = 0;
    fetch_ready = 0; redirect_target = 32'h0; trap_vector = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_pc(logic [31:0] a);
    trap_valid = 1'b1; trap_vector = a;
    tick();
    trap_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc0 !== 32'h1000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc0, 32'h1000); end
    checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", fv0); end
    checks++; if (cnt0 !== 32'h0 || err0 !== 1'b0 || addr0 !== 32'h0) begin failures++; $display("FAIL reset_misc cnt=%h err=%b addr=%h exp=0", cnt0, err0, addr0); end
    fetch_ready = 1'b1;
    tick();
    checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL boot_fv got=%b exp=0", fv0); end
    tick();
    checks++; if (fv0 !== 1'b1 || fv1 !== 1'b1) begin failures++; $display("FAIL run_fv got=%b/%b exp=1", fv0, fv1); end
    checks++; if (pc0 !== 32'h1000) begin failures++; $display("FAIL run_pc got=%h exp=%h", pc0, 32'h1000); end
    checks++; if (pcn0 !== 32'h1004) begin failures++; $display("FAIL run_pc_next got=%h exp=%h", pcn0, 32'h1004); end
    tick();
    checks++; if (pc0 !== 32'h1004) begin failures++; $display("FAIL seq_pc1 got=%h exp=%h", pc0, 32'h1004); end
    tick();
    checks++; if (pc0 !== 32'h1008) begin failures++; $display("FAIL seq_pc2 got=%h exp=%h", pc0, 32'h1008); end
    checks++; if (cnt0 !== 32'd2 || cnt1 !== 4'd2) begin failures++; $display("FAIL seq_count got=%0d/%0d exp=2", cnt0, cnt1); end
    idle();
  endtask

  task automatic test_stall();
    logic [31:0] c;
    set_pc(32'h2000);
    c = mcnt[0];
    stall = 1'b1; fetch_ready = 1'b1;
    repeat (3) tick();
    stall = 1'b0; fetch_ready = 1'b0;
    repeat (2) tick();
    checks++; if (pc0 !== 32'h2000 || pc1 !== 32'h2000) begin failures++; $display("FAIL stall_pc got=%h/%h exp=%h", pc0, pc1, 32'h2000); end
    checks++; if (cnt0 !== c) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", cnt0, c); end
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc0 !== 32'h2004) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", pc0, 32'h2004); end
    checks++; if (cnt0 !== c + 32'd1) begin failures++; $display("FAIL stall_release_count got=%0d exp=%0d", cnt0, c + 32'd1); end
    idle();
  endtask

  task automatic test_priority();
    set_pc(32'h100);
    stall = 1'b1;
    trap_valid = 1'b1; trap_vector = 32'h8000_0000;
    redirect_valid = 1'b1; redirect_target = 32'h400;
    #1;
    checks++; if (pcn0 !== 32'h8000_0000) begin failures++; $display("FAIL prio_pc_next got=%h exp=%h", pcn0, 32'h8000_0000); end
    tick();
    checks++; if (pc0 !== 32'h8000_0000) begin failures++; $display("FAIL prio_trap_pc got=%h exp=%h", pc0, 32'h8000_0000); end
    checks++; if (err0 !== 1'b0 || err1 !== 1'b0) begin failures++; $display("FAIL prio_err got=%b/%b exp=0", err0, err1); end
    trap_valid = 1'b0;
    tick();
    checks++; if (pc0 !== 32'h400) begin failures++; $display("FAIL prio_redirect_pc got=%h exp=%h", pc0, 32'h400); end
    idle();
  endtask

  task automatic test_misalign();
    set_pc(32'h200);
    fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    checks++; if (pc0 !== 32'h204) begin failures++; $display("FAIL mis_pc0 got=%h exp=%h", pc0, 32'h204); end
    checks++; if (err0 !== 1'b1 || addr0 !== 32'h102) begin failures++; $display("FAIL mis_err0 err=%b addr=%h exp=1/%h", err0, addr0, 32'h102); end
    checks++; if (pc1 !== 32'h102 || err1 !== 1'b0) begin failures++; $display("FAIL mis_c pc=%h err=%b exp=%h/0", pc1, err1, 32'h102); end
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    tick();
    checks++; if (err0 !== 1'b0 || addr0 !== 32'h102) begin failures++; $display("FAIL mis_pulse err=%b addr=%h exp=0/%h", err0, addr0, 32'h102); end
    idle();
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    fetch_ready = 1'b1; instr_c = 1'b0;
    tick();
    checks++; if (pc0 !== 32'h0 || pc1 !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=0", pc0, pc1); end
    instr_c = 1'b1;
    tick();
    checks++; if (pc1 !== 32'h2 || pc0 !== 32'h4) begin failures++; $display("FAIL compressed_pc got=%h/%h exp=4/2", pc0, pc1); end
    idle();
  endtask

  task automatic test_halt();
    set_pc(32'h40);
    halt_req = 1'b1; fetch_ready = 1'b1;
    tick();
    checks++; if (pc0 !== 32'h44 || fv0 !== 1'b0) begin failures++; $display("FAIL halt_enter pc=%h fv=%b exp=%h/0", pc0, fv0, 32'h44); end
    trap_valid = 1'b1; trap_vector = 32'h80;
    tick();
    checks++; if (pc0 !== 32'h80 || fv0 !== 1'b0) begin failures++; $display("FAIL halt_trap pc=%h fv=%b exp=%h/0", pc0, fv0, 32'h80); end
    trap_valid = 1'b0;
    tick();
    checks++; if (pc0 !== 32'h80) begin failures++; $display("FAIL halt_hold got=%h exp=%h", pc0, 32'h80); end
    halt_req = 1'b0;
    tick();
    checks++; if (fv0 !== 1'b1 || pc0 !== 32'h80) begin failures++; $display("FAIL halt_leave fv=%b pc=%h exp=1/%h", fv0, pc0, 32'h80); end
    // Assert reset between clock edges; outputs must react without an edge.
    #2 rst = 1'b1;
    #1;
    checks++; if (pc0 !== 32'h1000 || pc1 !== 32'h1000) begin failures++; $display("FAIL async_rst_pc got=%h/%h exp=%h", pc0, pc1, 32'h1000); end
    checks++; if (fv0 !== 1'b0 || cnt0 !== 32'h0) begin failures++; $display("FAIL async_rst_state fv=%b cnt=%h exp=0", fv0, cnt0); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      stall           = ($urandom % 4) == 0;
      fetch_ready     = ($urandom % 4) != 0;
      halt_req        = ($urandom % 10) == 0;
      redirect_valid  = ($urandom % 6) == 0;
      redirect_target = $urandom;
      trap_valid      = ($urandom % 16) == 0;
      trap_vector     = $urandom;
      instr_c         = $urandom % 2;
      if (($urandom % 4) == 0) redirect_target = 32'hFFFF_FFF0 | 32'($urandom % 16);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_pcn[i] !== m_next(i)) begin failures++; $display("FAIL rnd_pc_next[%0d] n=%0d got=%h exp=%h", i, n, o_pcn[i], m_next(i)); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_pc[i] !== mpc[i]) begin failures++; $display("FAIL rnd_pc[%0d] n=%0d got=%h exp=%h", i, n, o_pc[i], mpc[i]); end
        checks++; if (o_fv[i] !== m_fv(i)) begin failures++; $display("FAIL rnd_fv[%0d] n=%0d got=%b exp=%b", i, n, o_fv[i], m_fv(i)); end
        checks++; if (o_err[i] !== merr[i] || o_addr[i] !== maddr[i]) begin failures++; $display("FAIL rnd_err[%0d] n=%0d got=%b/%h exp=%b/%h", i, n, o_err[i], o_addr[i], merr[i], maddr[i]); end
        checks++; if (o_cnt[i] !== mcnt[i]) begin failures++; $display("FAIL rnd_cnt[%0d] n=%0d got=%0d exp=%0d", i, n, o_cnt[i], mcnt[i]); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_stall();
    test_priority();
    test_misalign();
    test_wrap();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
